shift_add_multiplier: RTL

Multi-cycle unsigned multiplier that sequences one WIDTH-bit Adder through WIDTH shift-and-add steps instead of instantiating a combinational array. It sits beside the ALU in the execute stage and serves MUL/MULHU-class operations. The core issues a start pulse and stalls on `busy`, then captures the full 2·WIDTH-bit product on the `done` pulse.

---
 rtl/shift_add_multiplier_pkg.sv | 17 +
 rtl/shift_add_multiplier_adder.sv | 14 +
 rtl/shift_add_multiplier.sv | 92 +++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encodings and step-counter sizing.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // One add/shift step per operand bit; the counter only has to reach WIDTH-1.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// WIDTH-bit ripple adder with carry in/out, shared by the multiplier datapath.
module shift_add_multiplier_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned multiplier: one adder reused over WIDTH shift-and-add steps,
// full 2*WIDTH-bit product delivered with a single-cycle done pulse.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int              CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("shift_add_multiplier: WIDTH must be >= 2");
        end
    endgenerate

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_nx;
    logic [WIDTH-1:0]   hi, lo, addend, sum;
    logic               carry;

    assign hi     = prod[2*WIDTH-1:WIDTH];
    assign lo     = prod[WIDTH-1:0];
    assign addend = lo[0] ? mcand : '0;

    shift_add_multiplier_adder #(.WIDTH(WIDTH)) u_adder (
        .x         (hi),
        .y         (addend),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry)
    );

    // Carry becomes the new top bit of hi so the shift never drops a product bit.
    assign prod_nx = {carry, sum, lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand <= a;
                    prod  <= {{WIDTH{1'b0}}, b};
                    cnt   <= '0;
                end
                RUN: begin
                    prod <= prod_nx;
                    cnt  <= cnt + CNT_W'(1);
                    // Load on the final step so result is already valid in DONE.
                    if (cnt == LAST) result <= prod_nx;
                end
                default: ;
            endcase
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
        end
    end

endmodule
